arb8_burst: RTL



---
 rtl/arb8_burst_pkg.sv | 22 ++
 rtl/arb8_burst_if.sv | 45 ++++
 rtl/arb8_burst_rr_pick8.sv | 38 +++
 rtl/arb8_burst.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/arb8_burst_pkg.sv
// Shared constants, state encoding and grant decode for the 8-way burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: N_REQ, SEL_W, DEFAULT_DW, DEFAULT_TIMEOUT, state_t, onehot8().
package arb8_pkg;

  localparam int N_REQ           = 8;
  localparam int SEL_W           = 3;
  localparam int DEFAULT_DW      = 8;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Grant vector for a requester index.
  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/arb8_burst_if.sv
// Requester/resource bundle between the mux8/demux8 steering and the shared consumer.
// Latency: n/a (wires only).
// Backpressure: res_ready from the consumer stalls the granted requester.
// Ports: req/req_last/req_data/res_ready into the arbiter; gnt/sel/busy/res_* out;
//        err_timeout exists only when ARB_TIMEOUT_EN is defined.
//        slave = arbiter side, master = requesters + consumer side.
interface arb8_burst_if #(
  parameter int DW = arb8_pkg::DEFAULT_DW
) ();

  logic [7:0]      req;
  logic [7:0]      req_last;
  logic [8*DW-1:0] req_data;
  logic [7:0]      gnt;
  logic [2:0]      sel;
  logic            busy;
  logic            res_valid;
  logic [DW-1:0]   res_data;
  logic            res_last;
  logic            res_ready;
`ifdef ARB_TIMEOUT_EN
  logic            err_timeout;

  modport slave (
    input  req, req_last, req_data, res_ready,
    output gnt, sel, busy, res_valid, res_data, res_last, err_timeout
  );

  modport master (
    output req, req_last, req_data, res_ready,
    input  gnt, sel, busy, res_valid, res_data, res_last, err_timeout
  );
`else
  modport slave (
    input  req, req_last, req_data, res_ready,
    output gnt, sel, busy, res_valid, res_data, res_last
  );

  modport master (
    output req, req_last, req_data, res_ready,
    input  gnt, sel, busy, res_valid, res_data, res_last
  );
`endif

endinterface

// File: rtl/arb8_burst_rr_pick8.sv
// Round-robin picker: first asserted request at or after ptr, wrapping mod 8.
// Latency: combinational.
// Backpressure: none.
// Ports: req[7:0], ptr[2:0] in; found (any request), idx[2:0] (winner) out.
module rr_pick8
  import arb8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate so that bit 0 is the requester at ptr.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      logic [SEL_W-1:0] j;
      j      = ptr + SEL_W'(i);
      rot[i] = req[j];
    end
  end

  // Lowest set bit of the rotated vector wins (scan downward, last hit sticks).
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign found = |req;
  assign idx   = ptr + off;

endmodule

// File: rtl/arb8_burst.sv
// Per-burst round-robin arbiter sharing one resource port among 8 requesters.
// Latency: grant 1 cycle after req in IDLE; zero-bubble regrant after a last beat.
// Backpressure: res_ready low stalls the granted burst; no preemption (except timeout).
// Ports: clk, rst (sync, active-high); bus (arb8_burst_if.slave) carrying
//        req/req_last/req_data/res_ready in and gnt/sel/busy/res_valid/res_data/res_last out.
// Option: define ARB_TIMEOUT_EN to add the TIMEOUT parameter, a stall counter and
//         the err_timeout pulse that revokes a grant stuck for TIMEOUT cycles.
module arb8_burst
  import arb8_pkg::*;
#(
  parameter int DW = DEFAULT_DW
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
  input logic         clk,
  input logic         rst,
  arb8_burst_if.slave bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             busy;
  logic             accept;
  logic             last_done;
  logic             timeout_hit;
  logic             release_gnt;
  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] pick_ptr;
  logic             found;
  logic [SEL_W-1:0] pick_idx;

  // ---------------------------------------------------------------------------
  // Resource-side outputs: combinational from registered sel and live inputs.
  // ---------------------------------------------------------------------------
  assign busy          = (state_q == BUSY);
  assign bus.busy      = busy;
  assign bus.sel       = sel_q;
  assign bus.gnt       = busy ? onehot8(sel_q) : '0;
  assign bus.res_valid = busy & bus.req[sel_q];
  assign bus.res_data  = bus.req_data[int'(sel_q)*DW +: DW];
  assign bus.res_last  = bus.req_last[sel_q];

  assign accept      = bus.res_valid & bus.res_ready;
  assign last_done   = accept & bus.res_last;
  assign release_gnt = last_done | timeout_hit;

  // ---------------------------------------------------------------------------
  // Winner search. In IDLE search from ptr. In BUSY we search from sel+1, so the
  // holder naturally lands at lowest priority. A requester whose last beat is
  // being accepted still shows req high this cycle but has nothing left, so it
  // is masked out; after a timeout revocation it stays eligible (lowest prio).
  // ---------------------------------------------------------------------------
  always_comb begin
    cand     = bus.req;
    pick_ptr = ptr_q;
    if (busy) begin
      pick_ptr = sel_q + SEL_W'(1);
      if (last_done) cand = bus.req & ~onehot8(sel_q);
    end
  end

  rr_pick8 u_pick (
    .req   (cand),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_gnt) begin
          ptr_d = sel_q + SEL_W'(1);
          if (found) sel_d = pick_idx;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Stall watchdog: counts BUSY cycles with no accepted beat since the last
  // accept or grant; reaching TIMEOUT revokes the grant at the next edge.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic             new_grant;

  assign new_grant   = found & (~busy | release_gnt);
  assign timeout_hit = busy & (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != BUSY || new_grant || accept) cnt_d = '0;
    else if (cnt_q != CNT_W'(TIMEOUT))            cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_hit;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
